// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared definitions for the hazard-aware control pipeline: opcodes, ALUOp codes,
// per-stage control bundles and the capture-time sanitiser.
package hazard_ctrl_pipe_pkg;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [5:0] OP_ORI = 6'd13;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // Full decoded bundle as carried in ID/EX.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       bne;
    logic [1:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam int EX_CTRL_W  = $bits(ex_ctrl_t);
  localparam int MEM_CTRL_W = $bits(mem_ctrl_t);
  localparam int WB_CTRL_W  = $bits(wb_ctrl_t);

  // Anything other than a clean 1 (0, X, Z from an unimplemented opcode) becomes 0.
  function automatic logic is_one(input logic b);
    return (b === 1'b1);
  endfunction

  function automatic ex_ctrl_t sanitize(input ex_ctrl_t raw);
    ex_ctrl_t c;
    c.reg_dst    = is_one(raw.reg_dst);
    c.alu_src    = is_one(raw.alu_src);
    c.mem_to_reg = is_one(raw.mem_to_reg);
    c.reg_write  = is_one(raw.reg_write);
    c.mem_read   = is_one(raw.mem_read);
    c.mem_write  = is_one(raw.mem_write);
    c.branch     = is_one(raw.branch);
    c.jump       = is_one(raw.jump);
    c.bne        = is_one(raw.bne);
    c.alu_op     = {is_one(raw.alu_op[1]), is_one(raw.alu_op[0])};
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_pipe_ctrl_stage_reg.sv
// Pipeline stage register with async reset, load enable and a flush that loads all zeros.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_flush,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Flush beats enable so a bubble can be inserted even while the stage is held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_flush) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Control-path pipeline ID->EX->MEM->WB with load-use stall, EX branch / ID jump
// resolution, PC and IF/ID steering, and saturating stall/flush counters.
module hazard_ctrl_pipe
  import hazard_ctrl_pipe_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_reg_dst,
  input  logic             i_id_alu_src,
  input  logic             i_id_mem_to_reg,
  input  logic             i_id_reg_write,
  input  logic             i_id_mem_read,
  input  logic             i_id_mem_write,
  input  logic             i_id_branch,
  input  logic             i_id_jump,
  input  logic             i_id_bne,
  input  logic [1:0]       i_id_alu_op,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_ex_zero,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_pc_src_branch,
  output logic             o_pc_src_jump,
  output logic             o_ex_alu_src,
  output logic             o_ex_mem_read,
  output logic             o_ex_bne,
  output logic [1:0]       o_ex_alu_op,
  output logic [REG_W-1:0] o_ex_rs,
  output logic [REG_W-1:0] o_ex_rt,
  output logic [REG_W-1:0] o_ex_write_reg,
  output logic             o_mem_mem_read,
  output logic             o_mem_mem_write,
  output logic             o_mem_reg_write,
  output logic             o_mem_mem_to_reg,
  output logic [REG_W-1:0] o_mem_write_reg,
  output logic             o_wb_reg_write,
  output logic             o_wb_mem_to_reg,
  output logic [REG_W-1:0] o_wb_write_reg,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int IDEX_W  = EX_CTRL_W + 3 * REG_W;
  localparam int EXMEM_W = MEM_CTRL_W + REG_W;
  localparam int MEMWB_W = WB_CTRL_W + REG_W;

  ex_ctrl_t          w_id_raw;
  ex_ctrl_t          w_id_ctrl;
  ex_ctrl_t          w_ex_ctrl;
  mem_ctrl_t         w_mem_ctrl;
  mem_ctrl_t         w_mem_ctrl_d;
  wb_ctrl_t          w_wb_ctrl;
  wb_ctrl_t          w_wb_ctrl_d;
  logic [REG_W-1:0]  w_ex_rs;
  logic [REG_W-1:0]  w_ex_rt;
  logic [REG_W-1:0]  w_ex_rd;
  logic [REG_W-1:0]  w_ex_write_reg;
  logic [REG_W-1:0]  w_mem_write_reg;
  logic [REG_W-1:0]  w_wb_write_reg;
  logic [IDEX_W-1:0] w_idex_q;
  logic [EXMEM_W-1:0] w_exmem_q;
  logic [MEMWB_W-1:0] w_memwb_q;
  logic              w_stall;
  logic              w_br_taken;
  logic              w_stall_eff;
  logic              w_jump_eff;
  logic              w_idex_flush;
  logic              w_flush_event;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  // ---------------- ID capture ----------------
  assign w_id_raw = '{reg_dst:    i_id_reg_dst,
                      alu_src:    i_id_alu_src,
                      mem_to_reg: i_id_mem_to_reg,
                      reg_write:  i_id_reg_write,
                      mem_read:   i_id_mem_read,
                      mem_write:  i_id_mem_write,
                      branch:     i_id_branch,
                      jump:       i_id_jump,
                      bne:        i_id_bne,
                      alu_op:     i_id_alu_op};

  // A jump travels on as a harmless marker: it must never write a register or memory.
  always_comb begin
    w_id_ctrl = sanitize(w_id_raw);
    if (w_id_ctrl.jump) begin
      w_id_ctrl.reg_write = 1'b0;
      w_id_ctrl.mem_read  = 1'b0;
      w_id_ctrl.mem_write = 1'b0;
    end
  end

  // ---------------- hazard resolution ----------------
  assign w_stall = w_ex_ctrl.mem_read && (w_ex_rt != '0) &&
                   ((w_ex_rt == i_id_rs) || (w_ex_rt == i_id_rt));

  assign w_br_taken = w_ex_ctrl.branch && !w_ex_ctrl.jump && (i_ex_zero ^ w_ex_ctrl.bne);

  // A taken branch squashes the ID instruction, so its stall or jump is moot.
  assign w_stall_eff   = w_stall && !w_br_taken;
  assign w_jump_eff    = w_id_ctrl.jump && !w_stall && !w_br_taken;
  assign w_idex_flush  = w_br_taken || w_stall;
  assign w_flush_event = w_br_taken || w_jump_eff;

  always_comb begin
    o_pc_write      = 1'b1;
    o_if_id_write   = 1'b1;
    o_if_id_flush   = 1'b0;
    o_pc_src_branch = 1'b0;
    o_pc_src_jump   = 1'b0;
    if (w_br_taken) begin
      o_pc_src_branch = 1'b1;
      o_if_id_flush   = 1'b1;
    end else if (w_stall_eff) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
    end else if (w_jump_eff) begin
      o_pc_src_jump = 1'b1;
      o_if_id_flush = 1'b1;
    end
  end

  // ---------------- ID/EX ----------------
  ctrl_stage_reg #(.W(IDEX_W)) u_id_ex (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .i_flush (w_idex_flush),
    .i_d     ({w_id_ctrl, i_id_rs, i_id_rt, i_id_rd}),
    .o_q     (w_idex_q)
  );

  assign {w_ex_ctrl, w_ex_rs, w_ex_rt, w_ex_rd} = w_idex_q;
  assign w_ex_write_reg = w_ex_ctrl.reg_dst ? w_ex_rd : w_ex_rt;

  // ---------------- EX/MEM ----------------
  assign w_mem_ctrl_d = '{mem_read:   w_ex_ctrl.mem_read,
                          mem_write:  w_ex_ctrl.mem_write,
                          reg_write:  w_ex_ctrl.reg_write,
                          mem_to_reg: w_ex_ctrl.mem_to_reg};

  ctrl_stage_reg #(.W(EXMEM_W)) u_ex_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .i_flush (1'b0),
    .i_d     ({w_mem_ctrl_d, w_ex_write_reg}),
    .o_q     (w_exmem_q)
  );

  assign {w_mem_ctrl, w_mem_write_reg} = w_exmem_q;

  // ---------------- MEM/WB ----------------
  assign w_wb_ctrl_d = '{reg_write:  w_mem_ctrl.reg_write,
                         mem_to_reg: w_mem_ctrl.mem_to_reg};

  ctrl_stage_reg #(.W(MEMWB_W)) u_mem_wb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .i_flush (1'b0),
    .i_d     ({w_wb_ctrl_d, w_mem_write_reg}),
    .o_q     (w_memwb_q)
  );

  assign {w_wb_ctrl, w_wb_write_reg} = w_memwb_q;

  // ---------------- saturating counters ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_eff && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_event && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // ---------------- outputs ----------------
  assign o_ex_alu_src     = w_ex_ctrl.alu_src;
  assign o_ex_mem_read    = w_ex_ctrl.mem_read;
  assign o_ex_bne         = w_ex_ctrl.bne;
  assign o_ex_alu_op      = w_ex_ctrl.alu_op;
  assign o_ex_rs          = w_ex_rs;
  assign o_ex_rt          = w_ex_rt;
  assign o_ex_write_reg   = w_ex_write_reg;
  assign o_mem_mem_read   = w_mem_ctrl.mem_read;
  assign o_mem_mem_write  = w_mem_ctrl.mem_write;
  assign o_mem_reg_write  = w_mem_ctrl.reg_write;
  assign o_mem_mem_to_reg = w_mem_ctrl.mem_to_reg;
  assign o_mem_write_reg  = w_mem_write_reg;
  assign o_wb_reg_write   = w_wb_ctrl.reg_write;
  assign o_wb_mem_to_reg  = w_wb_ctrl.mem_to_reg;
  assign o_wb_write_reg   = w_wb_write_reg;
  assign o_stall_cnt      = r_stall_cnt;
  assign o_flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: hand-worked instruction sequences with
// expected control outputs, counters and reset behaviour.
module tb_hazard_ctrl_pipe;

  localparam int CNT_W = 4;
  localparam int REG_W = 5;

  localparam int OP_R = 0, OP_J = 2, OP_BEQ = 4, OP_BNE = 5, OP_ORI = 13;
  localparam int OP_LW = 35, OP_SW = 43, OP_NOP = 100, OP_BAD = 63;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read;
  logic             id_mem_write, id_branch, id_jump, id_bne;
  logic [1:0]       id_alu_op;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             ex_zero;

  logic             pc_write, if_id_write, if_id_flush, pc_src_branch, pc_src_jump;
  logic             ex_alu_src, ex_mem_read, ex_bne;
  logic [1:0]       ex_alu_op;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_write_reg;
  logic             mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
  logic [REG_W-1:0] mem_write_reg;
  logic             wb_reg_write, wb_mem_to_reg;
  logic [REG_W-1:0] wb_write_reg;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl_pipe #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_id_reg_dst     (id_reg_dst),
    .i_id_alu_src     (id_alu_src),
    .i_id_mem_to_reg  (id_mem_to_reg),
    .i_id_reg_write   (id_reg_write),
    .i_id_mem_read    (id_mem_read),
    .i_id_mem_write   (id_mem_write),
    .i_id_branch      (id_branch),
    .i_id_jump        (id_jump),
    .i_id_bne         (id_bne),
    .i_id_alu_op      (id_alu_op),
    .i_id_rs          (id_rs),
    .i_id_rt          (id_rt),
    .i_id_rd          (id_rd),
    .i_ex_zero        (ex_zero),
    .o_pc_write       (pc_write),
    .o_if_id_write    (if_id_write),
    .o_if_id_flush    (if_id_flush),
    .o_pc_src_branch  (pc_src_branch),
    .o_pc_src_jump    (pc_src_jump),
    .o_ex_alu_src     (ex_alu_src),
    .o_ex_mem_read    (ex_mem_read),
    .o_ex_bne         (ex_bne),
    .o_ex_alu_op      (ex_alu_op),
    .o_ex_rs          (ex_rs),
    .o_ex_rt          (ex_rt),
    .o_ex_write_reg   (ex_write_reg),
    .o_mem_mem_read   (mem_mem_read),
    .o_mem_mem_write  (mem_mem_write),
    .o_mem_reg_write  (mem_reg_write),
    .o_mem_mem_to_reg (mem_mem_to_reg),
    .o_mem_write_reg  (mem_write_reg),
    .o_wb_reg_write   (wb_reg_write),
    .o_wb_mem_to_reg  (wb_mem_to_reg),
    .o_wb_write_reg   (wb_write_reg),
    .o_stall_cnt      (stall_cnt),
    .o_flush_cnt      (flush_cnt)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Reference MIPS decoder; mem_to_reg = 1 selects the ALU result.
  task automatic set_id(input int op, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic [REG_W-1:0] rd);
    {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
     id_mem_write, id_branch, id_jump, id_bne} = '0;
    id_alu_op = 2'b00;
    case (op)
      OP_R:   begin id_reg_dst = 1; id_mem_to_reg = 1; id_reg_write = 1; id_alu_op = 2'b10; end
      OP_LW:  begin id_alu_src = 1; id_reg_write = 1; id_mem_read = 1; end
      OP_SW:  begin id_alu_src = 1; id_mem_write = 1; end
      OP_BEQ: begin id_branch = 1; id_alu_op = 2'b01; end
      OP_BNE: begin id_branch = 1; id_bne = 1; id_alu_op = 2'b01; end
      OP_J:   id_jump = 1;
      OP_ORI: begin id_alu_src = 1; id_mem_to_reg = 1; id_reg_write = 1; id_alu_op = 2'b11; end
      OP_BAD: begin
        {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
         id_mem_write, id_branch, id_jump, id_bne} = 'x;
        id_alu_op = 'x;
      end
      default: ;
    endcase
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex_zero = 1'b0;
    set_id(OP_NOP, 0, 0, 0);
    step();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    do_reset();
    check("rst_pc_write", pc_write, 1);
    check("rst_if_id_write", if_id_write, 1);
    check("rst_if_id_flush", if_id_flush, 0);
    check("rst_selects", {pc_src_branch, pc_src_jump}, 0);
    check("rst_stages", {ex_mem_read, ex_write_reg, mem_reg_write, mem_write_reg,
                         wb_reg_write, wb_write_reg}, 0);
    check("rst_counters", {stall_cnt, flush_cnt}, 0);

    // 1. lw $2,0($1); add $3,$2,$4
    set_id(OP_LW, 1, 2, 0);
    #1 check("lu_no_early_stall", pc_write, 1);
    step();
    set_id(OP_R, 2, 4, 3);
    #1;
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_if_id_flush", if_id_flush, 0);
    step();
    check("lu_bubble_mem_read", ex_mem_read, 0);
    check("lu_bubble_alu_op", ex_alu_op, 0);
    check("lu_bubble_wreg", ex_write_reg, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_mem_lw", {mem_mem_read, mem_write_reg}, {1'b1, 5'd2});
    check("lu_stall_once", pc_write, 1);
    step();
    check("lu_ex_add_wreg", ex_write_reg, 3);
    check("lu_ex_add_aluop", ex_alu_op, 2);
    check("lu_wb_lw", {wb_reg_write, wb_mem_to_reg, wb_write_reg}, {1'b1, 1'b0, 5'd2});
    check("lu_stall_cnt_hold", stall_cnt, 1);

    // 2. beq $1,$1 taken, wrong-path add squashed
    do_reset();
    set_id(OP_BEQ, 1, 1, 0);
    step();
    set_id(OP_R, 5, 6, 7);
    ex_zero = 1'b1;
    #1;
    check("beq_pc_src", pc_src_branch, 1);
    check("beq_flush", if_id_flush, 1);
    check("beq_pc_write", pc_write, 1);
    step();
    set_id(OP_NOP, 0, 0, 0);
    ex_zero = 1'b0;
    #1;
    check("beq_bubble1", {ex_write_reg, ex_alu_op, ex_rs}, 0);
    check("beq_flush_cnt", flush_cnt, 1);
    check("beq_pc_src_off", pc_src_branch, 0);
    step();
    check("beq_bubble2", {ex_write_reg, ex_alu_op}, 0);
    check("beq_mem_no_write", {mem_reg_write, mem_mem_write}, 0);
    check("beq_flush_cnt_hold", flush_cnt, 1);

    // bne: not taken with zero = 1, taken with zero = 0
    do_reset();
    set_id(OP_BNE, 1, 2, 0);
    step();
    set_id(OP_NOP, 0, 0, 0);
    ex_zero = 1'b1;
    #1;
    check("bne_ex_bne", ex_bne, 1);
    check("bne_not_taken", {pc_src_branch, if_id_flush}, 0);
    ex_zero = 1'b0;
    #1 check("bne_taken", pc_src_branch, 1);
    step();
    check("bne_flush_cnt", flush_cnt, 1);

    // 3. j in ID, no stall
    do_reset();
    set_id(OP_J, 0, 0, 0);
    #1;
    check("j_pc_src", pc_src_jump, 1);
    check("j_flush", if_id_flush, 1);
    check("j_pc_write", {pc_write, if_id_write}, 2'b11);
    step();
    set_id(OP_NOP, 0, 0, 0);
    #1;
    check("j_flush_cnt", flush_cnt, 1);
    check("j_pc_src_off", pc_src_jump, 0);
    step();
    check("j_mem_no_write", {mem_reg_write, mem_mem_write, mem_mem_read}, 0);
    step();
    check("j_wb_no_write", wb_reg_write, 0);

    // 4. stall, branch and jump together: branch wins
    do_reset();
    set_id(OP_LW, 1, 5, 0);
    id_branch = 1'b1;
    step();
    set_id(OP_J, 5, 0, 0);
    ex_zero = 1'b1;
    #1;
    check("pri_pc_write", {pc_write, if_id_write}, 2'b11);
    check("pri_branch", pc_src_branch, 1);
    check("pri_no_jump", pc_src_jump, 0);
    check("pri_flush", if_id_flush, 1);
    step();
    check("pri_stall_cnt", stall_cnt, 0);
    check("pri_flush_cnt", flush_cnt, 1);
    check("pri_squashed", ex_rs, 0);

    // stall with a jump in ID: jump deferred one cycle
    do_reset();
    set_id(OP_LW, 1, 2, 0);
    step();
    set_id(OP_J, 2, 0, 0);
    #1;
    check("sj_pc_write", pc_write, 0);
    check("sj_no_jump", {pc_src_jump, if_id_flush}, 0);
    step();
    check("sj_stall_cnt", stall_cnt, 1);
    check("sj_flush_cnt0", flush_cnt, 0);
    check("sj_jump_now", pc_src_jump, 1);
    step();
    check("sj_flush_cnt1", flush_cnt, 1);
    check("sj_j_in_ex", ex_rs, 2);

    // 5. unimplemented opcode, all controls X
    do_reset();
    set_id(OP_BAD, 1, 2, 3);
    step();
    check("x_ex_mem_read", ex_mem_read, 0);
    set_id(OP_NOP, 0, 0, 0);
    step();
    check("x_mem_write", mem_mem_write, 0);
    check("x_mem_reg_write", mem_reg_write, 0);
    step();
    check("x_wb_reg_write", wb_reg_write, 0);

    // 6. asynchronous reset with the pipe full
    do_reset();
    set_id(OP_J, 0, 0, 0);
    step();
    set_id(OP_LW, 1, 2, 0);
    step();
    set_id(OP_ORI, 3, 4, 0);
    step();
    set_id(OP_R, 6, 7, 8);
    step();
    check("mid_pre_wb", {wb_reg_write, wb_write_reg}, {1'b1, 5'd2});
    check("mid_pre_ex", ex_write_reg, 8);
    check("mid_pre_flush_cnt", flush_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wb", {wb_reg_write, wb_mem_to_reg, wb_write_reg}, 0);
    check("mid_rst_mem", {mem_reg_write, mem_mem_read, mem_write_reg}, 0);
    check("mid_rst_ex", {ex_write_reg, ex_alu_op, ex_alu_src}, 0);
    check("mid_rst_cnt", {stall_cnt, flush_cnt}, 0);
    check("mid_rst_pc_write", pc_write, 1);
    step();
    check("mid_rst_held", {ex_write_reg, mem_reg_write, wb_reg_write}, 0);
    rst = 1'b0;

    // saturation of the stall counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_id(OP_LW, 1, 2, 0);
      step();
      set_id(OP_R, 2, 4, 3);
      step();
      if (i == 14) check("sat_reach", stall_cnt, 15);
    end
    check("sat_hold", stall_cnt, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
